// File: rtl/nco_sweep_ctrl.sv
// rtl/nco_sweep_ctrl.sv - NCO frequency sweep controller (start/step/dwell/loop)
module nco_sweep_ctrl #(
  parameter int FREQ_CTRL_WORD_LEN = 8,
  parameter int STEP_CNT_BITS      = 4,
  parameter int DWELL_BITS         = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_we,
  input  logic [FREQ_CTRL_WORD_LEN-1:0] cfg_start_fcw,
  input  logic [FREQ_CTRL_WORD_LEN-1:0] cfg_step,
  input  logic [STEP_CNT_BITS-1:0]      cfg_num_steps,
  input  logic [DWELL_BITS-1:0]         cfg_dwell,
  input  logic                          cfg_loop,
  input  logic                          start,
  input  logic                          abort,
  output logic [FREQ_CTRL_WORD_LEN-1:0] delta_phi,
  output logic                          nco_ena,
  output logic                          busy,
  output logic                          done,
  output logic [STEP_CNT_BITS-1:0]      step_idx
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                        state;
  logic [FREQ_CTRL_WORD_LEN-1:0] start_fcw_q;
  logic [FREQ_CTRL_WORD_LEN-1:0] step_q;
  logic [STEP_CNT_BITS-1:0]      num_steps_q;
  logic [DWELL_BITS-1:0]         dwell_q;
  logic                          loop_q;
  logic [DWELL_BITS-1:0]         dwell_cnt;

  // A start issued together with a config write launches with the new values.
  logic [FREQ_CTRL_WORD_LEN-1:0] launch_fcw;
  logic [DWELL_BITS-1:0]         launch_dwell;
  logic                          cfg_open;
  logic                          start_ok;

  assign cfg_open     = (state != RUN);
  assign start_ok     = start && !abort && cfg_open;
  assign launch_fcw   = cfg_we ? cfg_start_fcw : start_fcw_q;
  assign launch_dwell = cfg_we ? cfg_dwell     : dwell_q;

  // Config registers: writable only outside RUN so a running sweep is stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_fcw_q <= '0;
      step_q      <= '0;
      num_steps_q <= '0;
      dwell_q     <= '0;
      loop_q      <= 1'b0;
    end else if (cfg_we && cfg_open) begin
      start_fcw_q <= cfg_start_fcw;
      step_q      <= cfg_step;
      num_steps_q <= cfg_num_steps;
      dwell_q     <= cfg_dwell;
      loop_q      <= cfg_loop;
    end
  end

  // Sweep FSM with registered outputs; abort overrides everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      delta_phi <= '0;
      nco_ena   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      step_idx  <= '0;
      dwell_cnt <= '0;
    end else if (abort) begin
      state     <= IDLE;
      delta_phi <= '0;
      nco_ena   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            state     <= RUN;
            delta_phi <= launch_fcw;
            step_idx  <= '0;
            dwell_cnt <= launch_dwell;
            nco_ena   <= 1'b1;
            busy      <= 1'b1;
            done      <= 1'b0;
          end else begin
            state   <= IDLE;
            nco_ena <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
          end
        end
        RUN: begin
          if (dwell_cnt != '0) begin
            dwell_cnt <= dwell_cnt - 1'b1;
          end else if (step_idx < num_steps_q) begin
            delta_phi <= delta_phi + step_q;
            step_idx  <= step_idx + 1'b1;
            dwell_cnt <= dwell_q;
          end else if (loop_q) begin
            delta_phi <= start_fcw_q;
            step_idx  <= '0;
            dwell_cnt <= dwell_q;
          end else begin
            state   <= DONE;
            done    <= 1'b1;
            nco_ena <= 1'b0;
            busy    <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          nco_ena <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// tb/tb_nco_sweep_ctrl.sv - directed self-checking bench for nco_sweep_ctrl
module tb_nco_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_we;
  logic [7:0] cfg_start_fcw;
  logic [7:0] cfg_step;
  logic [3:0] cfg_num_steps;
  logic [7:0] cfg_dwell;
  logic       cfg_loop;
  logic       start;
  logic       abort;
  logic [7:0] delta_phi;
  logic       nco_ena;
  logic       busy;
  logic       done;
  logic [3:0] step_idx;

  int checks = 0;
  int errors = 0;

  nco_sweep_ctrl #(
    .FREQ_CTRL_WORD_LEN(8),
    .STEP_CNT_BITS(4),
    .DWELL_BITS(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cfg_we(cfg_we),
    .cfg_start_fcw(cfg_start_fcw),
    .cfg_step(cfg_step),
    .cfg_num_steps(cfg_num_steps),
    .cfg_dwell(cfg_dwell),
    .cfg_loop(cfg_loop),
    .start(start),
    .abort(abort),
    .delta_phi(delta_phi),
    .nco_ena(nco_ena),
    .busy(busy),
    .done(done),
    .step_idx(step_idx)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [7:0] f, input logic [7:0] s, input logic [3:0] n,
                         input logic [7:0] d, input logic l);
    cfg_start_fcw = f; cfg_step = s; cfg_num_steps = n; cfg_dwell = d; cfg_loop = l;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cfg_we = 0; start = 0; abort = 0;
    set_cfg(8'd0, 8'd0, 4'd0, 8'd0, 1'b0);
    #12;
    checks++; if (delta_phi !== 8'd0) begin errors++; $display("FAIL reset_delta_phi got %0d exp 0", delta_phi); end
    checks++; if ({nco_ena, busy, done} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {nco_ena, busy, done}); end
    checks++; if (step_idx !== 4'd0) begin errors++; $display("FAIL reset_step_idx got %0d exp 0", step_idx); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_one_shot();
    logic [7:0] exp_f;
    set_cfg(8'd10, 8'd5, 4'd3, 8'd2, 1'b0);
    cfg_we = 1; tick(); cfg_we = 0;
    start = 1; tick(); start = 0;
    for (int i = 0; i < 12; i++) begin
      exp_f = 8'(10 + 5 * (i / 3));
      checks++; if (delta_phi !== exp_f) begin errors++; $display("FAIL oneshot_delta_phi[%0d] got %0d exp %0d", i, delta_phi, exp_f); end
      checks++; if (step_idx !== 4'(i / 3)) begin errors++; $display("FAIL oneshot_step_idx[%0d] got %0d exp %0d", i, step_idx, i / 3); end
      checks++; if ({nco_ena, busy, done} !== 3'b110) begin errors++; $display("FAIL oneshot_flags[%0d] got %b exp 110", i, {nco_ena, busy, done}); end
      tick();
    end
    checks++; if ({nco_ena, busy, done} !== 3'b001) begin errors++; $display("FAIL oneshot_done_flags got %b exp 001", {nco_ena, busy, done}); end
    checks++; if (delta_phi !== 8'd25 || step_idx !== 4'd3) begin errors++; $display("FAIL oneshot_final got %0d/%0d exp 25/3", delta_phi, step_idx); end
    tick();
    checks++; if ({nco_ena, busy, done} !== 3'b000) begin errors++; $display("FAIL oneshot_after_done got %b exp 000", {nco_ena, busy, done}); end
    checks++; if (delta_phi !== 8'd25) begin errors++; $display("FAIL oneshot_idle_hold got %0d exp 25", delta_phi); end
  endtask

  task automatic test_wrap_negative();
    logic [7:0] exp_a [3];
    logic [7:0] exp_b [3];
    exp_a[0] = 8'd250; exp_a[1] = 8'd2; exp_a[2] = 8'd10;
    exp_b[0] = 8'd3;   exp_b[1] = 8'd1; exp_b[2] = 8'd255;
    set_cfg(8'd250, 8'd8, 4'd2, 8'd0, 1'b0);
    cfg_we = 1; start = 1; tick(); cfg_we = 0; start = 0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (delta_phi !== exp_a[i]) begin errors++; $display("FAIL wrap_delta_phi[%0d] got %0d exp %0d", i, delta_phi, exp_a[i]); end
      tick();
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL wrap_done got %b exp 1", done); end
    // restart from DONE with a simultaneous config write
    set_cfg(8'd3, 8'hFE, 4'd2, 8'd0, 1'b0);
    cfg_we = 1; start = 1; tick(); cfg_we = 0; start = 0;
    checks++; if ({busy, done} !== 2'b10) begin errors++; $display("FAIL restart_from_done got %b exp 10", {busy, done}); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (delta_phi !== exp_b[i]) begin errors++; $display("FAIL neg_delta_phi[%0d] got %0d exp %0d", i, delta_phi, exp_b[i]); end
      tick();
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL neg_done got %b exp 1", done); end
    tick();
  endtask

  task automatic test_loop();
    logic [7:0] exp_f;
    set_cfg(8'd0, 8'd1, 4'd1, 8'd1, 1'b1);
    cfg_we = 1; start = 1; tick(); cfg_we = 0; start = 0;
    for (int i = 0; i < 14; i++) begin
      exp_f = 8'((i / 2) % 2);
      checks++; if (delta_phi !== exp_f) begin errors++; $display("FAIL loop_delta_phi[%0d] got %0d exp %0d", i, delta_phi, exp_f); end
      checks++; if ({nco_ena, busy, done} !== 3'b110) begin errors++; $display("FAIL loop_flags[%0d] got %b exp 110", i, {nco_ena, busy, done}); end
      tick();
    end
    abort = 1; tick(); abort = 0;
    checks++; if ({nco_ena, busy, done} !== 3'b000) begin errors++; $display("FAIL loop_abort_flags got %b exp 000", {nco_ena, busy, done}); end
    checks++; if (delta_phi !== 8'd0) begin errors++; $display("FAIL loop_abort_delta_phi got %0d exp 0", delta_phi); end
  endtask

  task automatic test_cfg_lock();
    set_cfg(8'd20, 8'd4, 4'd1, 8'd0, 1'b0);
    cfg_we = 1; start = 1; tick(); cfg_we = 0; start = 0;
    checks++; if (delta_phi !== 8'd20) begin errors++; $display("FAIL lock_first got %0d exp 20", delta_phi); end
    set_cfg(8'd99, 8'd1, 4'd5, 8'd3, 1'b1);
    cfg_we = 1; start = 1; tick(); cfg_we = 0; start = 0;
    checks++; if (delta_phi !== 8'd24 || step_idx !== 4'd1) begin errors++; $display("FAIL lock_running got %0d/%0d exp 24/1", delta_phi, step_idx); end
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL lock_done got %b exp 1", done); end
    tick();
    start = 1; tick(); start = 0;
    checks++; if (delta_phi !== 8'd20 || busy !== 1'b1) begin errors++; $display("FAIL lock_old_cfg got %0d/%b exp 20/1", delta_phi, busy); end
    tick();
    checks++; if (delta_phi !== 8'd24) begin errors++; $display("FAIL lock_old_step got %0d exp 24", delta_phi); end
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL lock_old_done got %b exp 1", done); end
    tick();
  endtask

  task automatic test_priority();
    start = 1; abort = 1; tick(); start = 0; abort = 0;
    checks++; if ({nco_ena, busy, done} !== 3'b000 || delta_phi !== 8'd0) begin errors++; $display("FAIL prio_idle got %b/%0d exp 000/0", {nco_ena, busy, done}, delta_phi); end
    start = 1; tick(); start = 0;
    checks++; if (busy !== 1'b1 || delta_phi !== 8'd20) begin errors++; $display("FAIL prio_start got %b/%0d exp 1/20", busy, delta_phi); end
    tick();
    checks++; if (step_idx !== 4'd1 || delta_phi !== 8'd24) begin errors++; $display("FAIL prio_last got %0d/%0d exp 1/24", step_idx, delta_phi); end
    abort = 1; tick(); abort = 0;
    checks++; if ({nco_ena, busy, done} !== 3'b000 || delta_phi !== 8'd0) begin errors++; $display("FAIL prio_abort_final got %b/%0d exp 000/0", {nco_ena, busy, done}, delta_phi); end
    tick();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL prio_no_done got %b exp 0", done); end
  endtask

  task automatic test_reset_mid_run();
    set_cfg(8'd40, 8'd3, 4'd4, 8'd1, 1'b0);
    cfg_we = 1; start = 1; tick(); cfg_we = 0; start = 0;
    tick(); tick();
    checks++; if (delta_phi !== 8'd43 || busy !== 1'b1) begin errors++; $display("FAIL rst_pre got %0d/%b exp 43/1", delta_phi, busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({nco_ena, busy, done} !== 3'b000 || delta_phi !== 8'd0 || step_idx !== 4'd0) begin errors++; $display("FAIL rst_async got %b/%0d/%0d exp 000/0/0", {nco_ena, busy, done}, delta_phi, step_idx); end
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (busy !== 1'b0 || nco_ena !== 1'b0) begin errors++; $display("FAIL rst_stay_idle[%0d] got %b%b exp 00", i, busy, nco_ena); end
    end
    start = 1; tick(); start = 0;
    checks++; if (busy !== 1'b1 || delta_phi !== 8'd0) begin errors++; $display("FAIL rst_cfg_cleared got %b/%0d exp 1/0", busy, delta_phi); end
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL rst_cfg_single got %b exp 1", done); end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_wrap_negative();
    test_loop();
    test_cfg_lock();
    test_priority();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
